// File: rtl/gradient_magnitude.sv
// rtl/gradient_magnitude.sv - per-pixel |dx|+|dy| gradient magnitude, saturated, over a raster stream
module gradient_magnitude #(
  parameter int LINE_WIDTH = 640,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             line_start,
  input  logic             frame_start,
  output logic [PIX_W-1:0] grad_out,
  output logic             grad_valid,
  output logic             grad_border
);

  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_WIDTH - 1);

  logic             accept;
  logic [CW-1:0]    col;
  logic             first_row;
  logic [PIX_W-1:0] prev_pix;

  logic [CW-1:0]    eff_col;
  logic             eff_row0;
  logic [CW-1:0]    col_nxt;
  logic             row_nxt;

  logic [PIX_W-1:0] line_buf [LINE_WIDTH];

  logic             s1_valid;
  logic [PIX_W-1:0] s1_pix;
  logic [PIX_W-1:0] s1_prev;
  logic [PIX_W-1:0] s1_above;
  logic             s1_col0;
  logic             s1_row0;

  logic [PIX_W-1:0] gx;
  logic [PIX_W-1:0] gy;
  logic [PIX_W:0]   sum;
  logic [PIX_W-1:0] sat;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    logic signed [PIX_W:0] d;
    logic        [PIX_W:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = d[PIX_W] ? -d : d;
    return m[PIX_W-1:0];
  endfunction

  assign accept = enb & pix_valid;

  // Position the current pixel occupies; frame_start outranks line_start.
  always_comb begin
    eff_col  = col;
    eff_row0 = first_row;
    if (frame_start) begin
      eff_col  = '0;
      eff_row0 = 1'b1;
    end else if (line_start) begin
      eff_col = '0;
      if (col != '0) eff_row0 = 1'b0;
    end
  end

  always_comb begin
    col_nxt = eff_col + CW'(1);
    row_nxt = eff_row0;
    if (eff_col == LAST_COL) begin
      col_nxt = '0;
      row_nxt = 1'b0;
    end
  end

  // Row-above storage; the S1 read below sees the value before this write.
  always_ff @(posedge clk) begin
    if (accept) line_buf[eff_col] <= pix_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      first_row <= 1'b1;
      prev_pix  <= '0;
      s1_valid  <= 1'b0;
      s1_pix    <= '0;
      s1_prev   <= '0;
      s1_above  <= '0;
      s1_col0   <= 1'b0;
      s1_row0   <= 1'b0;
    end else if (enb) begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_pix    <= pix_in;
        s1_prev   <= prev_pix;
        s1_above  <= line_buf[eff_col];
        s1_col0   <= (eff_col == '0);
        s1_row0   <= eff_row0;
        prev_pix  <= pix_in;
        col       <= col_nxt;
        first_row <= row_nxt;
      end
    end
  end

  always_comb begin
    gx  = s1_col0 ? '0 : abs_diff(s1_pix, s1_prev);
    gy  = s1_row0 ? '0 : abs_diff(s1_pix, s1_above);
    sum = {1'b0, gx} + {1'b0, gy};
    sat = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grad_out    <= '0;
      grad_valid  <= 1'b0;
      grad_border <= 1'b0;
    end else if (enb) begin
      grad_valid <= s1_valid;
      if (s1_valid) begin
        grad_out    <= sat;
        grad_border <= s1_col0 | s1_row0;
      end
    end
  end

endmodule

// File: tb/tb_gradient_magnitude.sv
// tb/tb_gradient_magnitude.sv - directed self-checking bench for gradient_magnitude
module tb_gradient_magnitude;

  logic       clk = 1'b0;
  logic       reset;
  logic       enb;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       line_start;
  logic       frame_start;
  logic [7:0] grad_out;
  logic       grad_valid;
  logic       grad_border;

  int checks = 0;
  int fails  = 0;

  gradient_magnitude #(.LINE_WIDTH(8), .PIX_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enb         (enb),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .grad_out    (grad_out),
    .grad_valid  (grad_valid),
    .grad_border (grad_border)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [7:0] a0, input logic [7:0] a1,
                                     input logic [7:0] a2, input logic [7:0] a3,
                                     input logic [7:0] a4, input logic [7:0] a5,
                                     input logic [7:0] a6, input logic [7:0] a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Streams n pixels; stall_at/gap_at (-1 = none) insert 3 enb=0 cycles or one
  // pix_valid=0 cycle before pixel index given. s1/s2 track which pixel sits in each stage.
  task automatic run(input string tag, input logic [63:0] p, input logic [63:0] e,
                     input logic [7:0] bmask, input int n, input bit fs, input bit ls,
                     input int stall_at, input int gap_at);
    int idx = 0;
    int s1 = -1;
    int s2 = -1;
    int stall_left = 3;
    bit gap_done = 0;
    for (int c = 0; c < n + 8; c++) begin
      enb = 1'b1; pix_valid = 1'b0; pix_in = 8'h00; line_start = 1'b0; frame_start = 1'b0;
      if (idx == stall_at && stall_left > 0) begin
        enb = 1'b0; pix_valid = 1'b1; pix_in = 8'hEE; frame_start = 1'b1;
        stall_left--;
      end else if (idx == gap_at && !gap_done) begin
        gap_done = 1;
        s2 = s1; s1 = -1;
      end else if (idx < n) begin
        pix_valid = 1'b1;
        pix_in = p[idx*8 +: 8];
        frame_start = fs && (idx == 0);
        line_start = ls && (idx == 0);
        s2 = s1; s1 = idx; idx++;
      end else begin
        s2 = s1; s1 = -1;
      end
      @(posedge clk); #1;
      chk({tag, "_valid"}, {8'd0, grad_valid}, {8'd0, s2 >= 0});
      if (s2 >= 0) begin
        chk({tag, "_out"}, {1'b0, grad_out}, {1'b0, e[s2*8 +: 8]});
        chk({tag, "_border"}, {8'd0, grad_border}, {8'd0, bmask[s2]});
      end
    end
  endtask

  initial begin
    reset = 1'b0; enb = 1'b1; pix_in = 8'd0; pix_valid = 1'b0;
    line_start = 1'b0; frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {1'b0, grad_out}, 9'd0);
    chk("rst_valid", {8'd0, grad_valid}, 9'd0);
    chk("rst_border", {8'd0, grad_border}, 9'd0);
    reset = 1'b1;

    // Reset asserted while an output is valid.
    frame_start = 1'b1; pix_valid = 1'b1; pix_in = 8'd10;
    @(posedge clk); #1;
    frame_start = 1'b0; pix_in = 8'd90;
    @(posedge clk); #1;
    chk("pre_rst_valid", {8'd0, grad_valid}, 9'd1);
    pix_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {8'd0, grad_valid}, 9'd0);
    chk("async_rst_out", {1'b0, grad_out}, 9'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run("after_rst", pk(77, 80, 0, 0, 0, 0, 0, 0), pk(0, 3, 0, 0, 0, 0, 0, 0),
        8'h03, 2, 0, 0, -1, -1);

    run("ramp", pk(10, 20, 30, 40, 50, 60, 70, 80), pk(0, 10, 10, 10, 10, 10, 10, 10),
        8'hFF, 8, 1, 0, -1, -1);

    run("vstep_r0", {8{8'd50}}, 64'd0, 8'hFF, 8, 1, 0, -1, -1);
    run("vstep_r1", {8{8'd200}}, {8{8'd150}}, 8'h01, 8, 0, 1, -1, -1);

    run("sat_r0", 64'd0, 64'd0, 8'hFF, 8, 1, 0, -1, -1);
    run("sat_r1", pk(0, 255, 0, 255, 0, 255, 0, 255), pk(0, 255, 255, 255, 255, 255, 255, 255),
        8'h01, 8, 0, 1, -1, -1);

    run("stall", pk(10, 20, 30, 40, 50, 60, 70, 80), pk(0, 10, 10, 10, 10, 10, 10, 10),
        8'hFF, 8, 1, 0, 4, 6);

    run("wrap_r0", pk(10, 20, 30, 40, 50, 60, 70, 80), pk(0, 10, 10, 10, 10, 10, 10, 10),
        8'hFF, 8, 1, 0, -1, -1);
    run("wrap_r1", {8{8'd100}}, pk(90, 80, 70, 60, 50, 40, 30, 20),
        8'h01, 8, 0, 0, -1, -1);

    run("early_r0", pk(10, 20, 30, 40, 50, 0, 0, 0), pk(0, 10, 10, 10, 10, 0, 0, 0),
        8'h1F, 5, 1, 0, -1, -1);
    run("early_r1", pk(60, 70, 0, 0, 0, 0, 0, 0), pk(50, 60, 0, 0, 0, 0, 0, 0),
        8'h01, 2, 0, 1, -1, -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
